// File: rtl/fruit_motion.sv
// ---------------------------------------------------------------------------
// fruit_motion
//   Per-fruit trajectory engine sitting directly upstream of the fruit
//   renderer. A spawn request launches one fruit from just below the screen;
//   its centre is then advanced once per video frame under gravity, bouncing
//   off the side walls and clamping at the top edge. The fruit is retired
//   either by a slice from the blade logic or by falling out of the bottom,
//   and a one-cycle pulse reports which of the two happened.
//
// Optional feature (compile-time macro FRUIT_FALL_EN):
//   When defined, a slice does not retire the fruit immediately. The fruit
//   enters a FALL state, stays visible, loses its horizontal speed and keeps
//   falling until it leaves the bottom, then retires silently (no missed).
//   When undefined, FALL does not exist and a slice retires the fruit.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   frame_tick    one-cycle pulse per frame (vsync)
//   spawn         launch request, honoured only while idle
//   spawn_x       launch column
//   spawn_vx      signed horizontal speed in px/frame
//   spawn_choice  fruit type (0 orange, 1 apple, 2 pomegranate, 3 pear)
//   slice         one-cycle hit indication from the blade logic
//   x0, y0        fruit centre to the renderer
//   choice        latched fruit type to the renderer
//   en            fruit visible
//   busy          fruit in flight
//   sliced        one-cycle pulse: fruit retired by a slice
//   missed        one-cycle pulse: fruit left the bottom unsliced
// ---------------------------------------------------------------------------
module fruit_motion #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int LAUNCH_VY = 24,
    parameter int GRAVITY   = 1,
    parameter int MAX_VY    = 15,
    parameter int HALF      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       spawn,
    input  logic [9:0] spawn_x,
    input  logic [3:0] spawn_vx,
    input  logic [1:0] spawn_choice,
    input  logic       slice,
    output logic [9:0] x0,
    output logic [9:0] y0,
    output logic [1:0] choice,
    output logic       en,
    output logic       busy,
    output logic       sliced,
    output logic       missed
);

    // Keep-out bounds for the centre, in both unsigned (register) and
    // signed 11-bit (arithmetic) forms.
    localparam logic [9:0]         X_LO      = 10'(HALF);
    localparam logic [9:0]         X_HI      = 10'(SCREEN_W - 1 - HALF);
    localparam logic [9:0]         Y_LO      = 10'(HALF);
    localparam logic [9:0]         Y_EXIT    = 10'(SCREEN_H + HALF);
    localparam logic signed [10:0] X_LO_S    = 11'(HALF);
    localparam logic signed [10:0] X_HI_S    = 11'(SCREEN_W - 1 - HALF);
    localparam logic signed [10:0] Y_LO_S    = 11'(HALF);
    localparam logic signed [5:0]  VY_LAUNCH = 6'(-LAUNCH_VY);
    localparam logic signed [6:0]  VY_GRAV   = 7'(GRAVITY);
    localparam logic signed [6:0]  VY_MAX    = 7'(MAX_VY);

`ifdef FRUIT_FALL_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_FLY    = 2'd2,
        S_FALL   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_FLY    = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [9:0]         x0_q, x0_d;
    logic [9:0]         y0_q, y0_d;
    logic [1:0]         choice_q, choice_d;
    // vx is one bit wider than spawn_vx so that negating -8 on a wall
    // bounce yields +8 instead of wrapping back to -8.
    logic signed [4:0]  vx_q, vx_d;
    logic signed [5:0]  vy_q, vy_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               sliced_q, sliced_d;
    logic               missed_q, missed_d;

    logic signed [10:0] x_ext, vx_wide, x_sum;
    logic signed [10:0] y_ext, vy_wide, y_sum;
    logic signed [6:0]  vy_inc;
    logic signed [5:0]  vy_upd;
    logic signed [4:0]  vx_upd;
    logic [9:0]         x_upd, y_upd;
    logic               exit_now;

    // Candidate per-frame update, computed every cycle from the current
    // position and speed; the FSM decides whether to commit it.
    always_comb begin
        x_ext   = {1'b0, x0_q};
        vx_wide = {{6{vx_q[4]}}, vx_q};
        x_sum   = x_ext + vx_wide;
        if (x_sum < X_LO_S) begin
            x_upd  = X_LO;
            vx_upd = -vx_q;
        end else if (x_sum > X_HI_S) begin
            x_upd  = X_HI;
            vx_upd = -vx_q;
        end else begin
            x_upd  = x_sum[9:0];
            vx_upd = vx_q;
        end

        // Position moves by the old vy; vy then gains gravity and saturates.
        y_ext   = {1'b0, y0_q};
        vy_wide = {{5{vy_q[5]}}, vy_q};
        y_sum   = y_ext + vy_wide;
        vy_inc  = {vy_q[5], vy_q} + VY_GRAV;
        vy_upd  = (vy_inc > VY_MAX) ? VY_MAX[5:0] : vy_inc[5:0];
        if (y_sum < Y_LO_S) begin
            y_upd  = Y_LO;
            vy_upd = '0;
        end else begin
            y_upd  = y_sum[9:0];
        end

        exit_now = (vy_upd > 6'sd0) && (y_upd >= Y_EXIT);
    end

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        choice_d = choice_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        sliced_d = 1'b0;
        missed_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (spawn) begin
                    state_d = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                if (spawn_x < X_LO) begin
                    x0_d = X_LO;
                end else if (spawn_x > X_HI) begin
                    x0_d = X_HI;
                end else begin
                    x0_d = spawn_x;
                end
                y0_d     = Y_EXIT;
                vy_d     = VY_LAUNCH;
                vx_d     = {spawn_vx[3], spawn_vx};
                choice_d = spawn_choice;
                state_d  = S_FLY;
            end

            S_FLY: begin
                // A slice wins over a coincident frame tick: the fruit is
                // retired at the position where it was hit.
                if (slice) begin
                    sliced_d = 1'b1;
`ifdef FRUIT_FALL_EN
                    vx_d     = '0;
                    state_d  = S_FALL;
`else
                    state_d  = S_IDLE;
`endif
                end else if (frame_tick) begin
                    x0_d = x_upd;
                    vx_d = vx_upd;
                    y0_d = y_upd;
                    vy_d = vy_upd;
                    if (exit_now) begin
                        missed_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end

`ifdef FRUIT_FALL_EN
            S_FALL: begin
                // vx is zero here, so only the vertical motion matters.
                if (frame_tick) begin
                    y0_d = y_upd;
                    vy_d = vy_upd;
                    if (exit_now) begin
                        state_d = S_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef FRUIT_FALL_EN
        en_d = (state_d == S_FLY) || (state_d == S_FALL);
`else
        en_d = (state_d == S_FLY);
`endif
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            choice_q <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            sliced_q <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            choice_q <= choice_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            sliced_q <= sliced_d;
            missed_q <= missed_d;
        end
    end

    assign x0     = x0_q;
    assign y0     = y0_q;
    assign choice = choice_q;
    assign en     = en_q;
    assign busy   = busy_q;
    assign sliced = sliced_q;
    assign missed = missed_q;

endmodule

// File: tb/tb_fruit_motion.sv
// ---------------------------------------------------------------------------
// tb_fruit_motion
//   Self-checking bench for fruit_motion with default parameters. Builds
//   with or without FRUIT_FALL_EN; slice-retirement expectations follow
//   the macro.
// ---------------------------------------------------------------------------
module tb_fruit_motion;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       spawn;
    logic [9:0] spawn_x;
    logic [3:0] spawn_vx;
    logic [1:0] spawn_choice;
    logic       slice;
    logic [9:0] x0;
    logic [9:0] y0;
    logic [1:0] choice;
    logic       en;
    logic       busy;
    logic       sliced;
    logic       missed;

    int checks;
    int failures;
    int sliced_cnt;
    int missed_cnt;
    int both_cnt;

    typedef struct {
        logic [9:0] sx;
        logic [3:0] svx;
        logic [1:0] sch;
        int         ticks;
        logic [9:0] ex;
        logic [9:0] ey;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] x0;
        logic [9:0] y0;
        logic       en;
        logic [1:0] choice;
    } exp_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];
    exp_t sb_q [$];

    fruit_motion dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .spawn        (spawn),
        .spawn_x      (spawn_x),
        .spawn_vx     (spawn_vx),
        .spawn_choice (spawn_choice),
        .slice        (slice),
        .x0           (x0),
        .y0           (y0),
        .choice       (choice),
        .en           (en),
        .busy         (busy),
        .sliced       (sliced),
        .missed       (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then sample 1 time unit later and tally output pulses.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (sliced) sliced_cnt++;
        if (missed) missed_cnt++;
        if (sliced && missed) both_cnt++;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic frameTick();
        frame_tick = 1'b1;
        applyStimulus();
        frame_tick = 1'b0;
        applyStimulus();
    endtask

    task automatic launchFruit(input logic [9:0] sx, input logic [3:0] svx, input logic [1:0] sch);
        spawn_x      = sx;
        spawn_vx     = svx;
        spawn_choice = sch;
        spawn        = 1'b1;
        applyStimulus();
        spawn = 1'b0;
        applyStimulus();
    endtask

    task automatic drainFall(input string tag);
        for (int n = 0; n < 100 && busy; n++) begin
            frameTick();
        end
        checkOutput({tag, ".drain_busy"}, int'(busy), 0);
    endtask

    task automatic retireFruit(input string tag);
        int s0;
        int m0;
        s0 = sliced_cnt;
        m0 = missed_cnt;
        slice = 1'b1;
        applyStimulus();
        slice = 1'b0;
        checkOutput({tag, ".sliced"}, int'(sliced), 1);
`ifdef FRUIT_FALL_EN
        checkOutput({tag, ".fall_en"}, int'(en), 1);
`else
        checkOutput({tag, ".en_off"}, int'(en), 0);
`endif
        applyStimulus();
        checkOutput({tag, ".sliced_end"}, int'(sliced), 0);
`ifdef FRUIT_FALL_EN
        drainFall(tag);
`endif
        checkOutput({tag, ".busy_off"}, int'(busy), 0);
        checkOutput({tag, ".slice_once"}, sliced_cnt - s0, 1);
        checkOutput({tag, ".no_miss"}, missed_cnt - m0, 0);
    endtask

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int s0;
        int m0;
        exp_t e;

        checks       = 0;
        failures     = 0;
        sliced_cnt   = 0;
        missed_cnt   = 0;
        both_cnt     = 0;
        rst_n        = 1'b1;
        frame_tick   = 1'b0;
        spawn        = 1'b0;
        spawn_x      = '0;
        spawn_vx     = '0;
        spawn_choice = '0;
        slice        = 1'b0;

        //  sx       svx    sch   ticks  ex       ey
        vecs[0]  = '{10'd320,  4'h0, 2'd2, 0,  10'd320, 10'd488};
        vecs[1]  = '{10'd320,  4'h0, 2'd2, 1,  10'd320, 10'd464};
        vecs[2]  = '{10'd320,  4'h0, 2'd2, 24, 10'd320, 10'd188};
        vecs[3]  = '{10'd320,  4'h0, 2'd2, 25, 10'd320, 10'd188};
        vecs[4]  = '{10'd320,  4'h0, 2'd2, 39, 10'd320, 10'd293};
        vecs[5]  = '{10'd320,  4'h0, 2'd2, 41, 10'd320, 10'd323};
        vecs[6]  = '{10'd630,  4'h5, 2'd1, 1,  10'd631, 10'd464};
        vecs[7]  = '{10'd630,  4'h5, 2'd1, 2,  10'd626, 10'd441};
        vecs[8]  = '{10'd0,    4'hD, 2'd3, 0,  10'd8,   10'd488};
        vecs[9]  = '{10'd0,    4'hD, 2'd3, 1,  10'd8,   10'd464};
        vecs[10] = '{10'd0,    4'hD, 2'd3, 2,  10'd11,  10'd441};
        vecs[11] = '{10'd1000, 4'h7, 2'd0, 0,  10'd631, 10'd488};
        vecs[12] = '{10'd5,    4'h8, 2'd0, 2,  10'd16,  10'd441};

        #2;
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst.x0", int'(x0), 0);
        checkOutput("rst.y0", int'(y0), 0);
        checkOutput("rst.choice", int'(choice), 0);
        checkOutput("rst.en", int'(en), 0);
        checkOutput("rst.busy", int'(busy), 0);
        checkOutput("rst.sliced", int'(sliced), 0);
        checkOutput("rst.missed", int'(missed), 0);
        rst_n = 1'b1;
        applyStimulus();

        $display("[TB] vector table");
        for (int i = 0; i < NVEC; i++) begin
            launchFruit(vecs[i].sx, vecs[i].svx, vecs[i].sch);
            e.name   = $sformatf("vec%0d", i);
            e.x0     = vecs[i].ex;
            e.y0     = vecs[i].ey;
            e.en     = 1'b1;
            e.choice = vecs[i].sch;
            sb_q.push_back(e);
            for (int t = 0; t < vecs[i].ticks; t++) begin
                frameTick();
            end
            e = sb_q.pop_front();
            checkOutput({e.name, ".x0"}, int'(x0), int'(e.x0));
            checkOutput({e.name, ".y0"}, int'(y0), int'(e.y0));
            checkOutput({e.name, ".en"}, int'(en), int'(e.en));
            checkOutput({e.name, ".choice"}, int'(choice), int'(e.choice));
            retireFruit(e.name);
        end

        $display("[TB] full flight to bottom exit");
        s0 = sliced_cnt;
        m0 = missed_cnt;
        launchFruit(10'd320, 4'h0, 2'd2);
        for (int t = 0; t < 51; t++) begin
            frameTick();
        end
        checkOutput("exit.y0_t51", int'(y0), 473);
        checkOutput("exit.en_t51", int'(en), 1);
        checkOutput("exit.nomiss_t51", missed_cnt - m0, 0);
        frame_tick = 1'b1;
        applyStimulus();
        frame_tick = 1'b0;
        checkOutput("exit.y0_t52", int'(y0), 488);
        checkOutput("exit.en", int'(en), 0);
        checkOutput("exit.missed", int'(missed), 1);
        checkOutput("exit.busy", int'(busy), 0);
        checkOutput("exit.sliced", int'(sliced), 0);
        applyStimulus();
        checkOutput("exit.missed_end", int'(missed), 0);
        checkOutput("exit.miss_once", missed_cnt - m0, 1);
        checkOutput("exit.no_slice", sliced_cnt - s0, 0);

        $display("[TB] slice and frame_tick together");
        s0 = sliced_cnt;
        m0 = missed_cnt;
        launchFruit(10'd320, 4'h0, 2'd2);
        for (int t = 0; t < 3; t++) begin
            frameTick();
        end
        checkOutput("both.y0_pre", int'(y0), 419);
        slice      = 1'b1;
        frame_tick = 1'b1;
        applyStimulus();
        slice      = 1'b0;
        frame_tick = 1'b0;
        checkOutput("both.y0", int'(y0), 419);
        checkOutput("both.sliced", int'(sliced), 1);
`ifdef FRUIT_FALL_EN
        checkOutput("both.en", int'(en), 1);
`else
        checkOutput("both.en", int'(en), 0);
`endif
        applyStimulus();
        checkOutput("both.sliced_end", int'(sliced), 0);
`ifdef FRUIT_FALL_EN
        drainFall("both");
`endif
        checkOutput("both.slice_once", sliced_cnt - s0, 1);
        checkOutput("both.no_miss", missed_cnt - m0, 0);

        $display("[TB] spawn while busy");
        launchFruit(10'd320, 4'h0, 2'd2);
        frameTick();
        spawn        = 1'b1;
        spawn_choice = 2'd1;
        spawn_x      = 10'd100;
        applyStimulus();
        applyStimulus();
        spawn = 1'b0;
        frameTick();
        checkOutput("busyspawn.choice", int'(choice), 2);
        checkOutput("busyspawn.x0", int'(x0), 320);
        checkOutput("busyspawn.y0", int'(y0), 441);
        checkOutput("busyspawn.busy", int'(busy), 1);
        retireFruit("busyspawn");

        $display("[TB] slice in idle, slice and tick during launch");
        s0 = sliced_cnt;
        slice = 1'b1;
        applyStimulus();
        slice = 1'b0;
        checkOutput("idle.sliced", int'(sliced), 0);
        checkOutput("idle.busy", int'(busy), 0);
        spawn_x      = 10'd200;
        spawn_vx     = 4'h0;
        spawn_choice = 2'd3;
        spawn        = 1'b1;
        applyStimulus();
        spawn      = 1'b0;
        slice      = 1'b1;
        frame_tick = 1'b1;
        applyStimulus();
        slice      = 1'b0;
        frame_tick = 1'b0;
        checkOutput("launch.x0", int'(x0), 200);
        checkOutput("launch.y0", int'(y0), 488);
        checkOutput("launch.en", int'(en), 1);
        checkOutput("launch.choice", int'(choice), 3);
        checkOutput("launch.no_slice", sliced_cnt - s0, 0);
        retireFruit("launch");

        $display("[TB] reset mid flight");
        launchFruit(10'd320, 4'h3, 2'd2);
        frameTick();
        frameTick();
        s0 = sliced_cnt;
        m0 = missed_cnt;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.x0", int'(x0), 0);
        checkOutput("midrst.y0", int'(y0), 0);
        checkOutput("midrst.choice", int'(choice), 0);
        checkOutput("midrst.en", int'(en), 0);
        checkOutput("midrst.busy", int'(busy), 0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        frameTick();
        checkOutput("midrst.busy_after", int'(busy), 0);
        checkOutput("midrst.no_slice", sliced_cnt - s0, 0);
        checkOutput("midrst.no_miss", missed_cnt - m0, 0);

`ifdef FRUIT_FALL_EN
        $display("[TB] fall after slice");
        s0 = sliced_cnt;
        m0 = missed_cnt;
        launchFruit(10'd320, 4'h2, 2'd0);
        for (int t = 0; t < 10; t++) begin
            frameTick();
        end
        checkOutput("fall.x0_t10", int'(x0), 340);
        checkOutput("fall.y0_t10", int'(y0), 293);
        slice = 1'b1;
        applyStimulus();
        slice = 1'b0;
        checkOutput("fall.sliced", int'(sliced), 1);
        checkOutput("fall.en", int'(en), 1);
        checkOutput("fall.busy", int'(busy), 1);
        frameTick();
        checkOutput("fall.x0_t11", int'(x0), 340);
        checkOutput("fall.y0_t11", int'(y0), 279);
        checkOutput("fall.en_t11", int'(en), 1);
        slice = 1'b1;
        applyStimulus();
        slice = 1'b0;
        checkOutput("fall.reslice", int'(sliced), 0);
        for (int t = 0; t < 40; t++) begin
            frameTick();
        end
        checkOutput("fall.y0_t51", int'(y0), 473);
        checkOutput("fall.busy_t51", int'(busy), 1);
        frameTick();
        checkOutput("fall.y0_exit", int'(y0), 488);
        checkOutput("fall.busy_exit", int'(busy), 0);
        checkOutput("fall.en_exit", int'(en), 0);
        checkOutput("fall.slice_once", sliced_cnt - s0, 1);
        checkOutput("fall.no_miss", missed_cnt - m0, 0);
`endif

        checkOutput("pulses.never_both", both_cnt, 0);
        checkOutput("scoreboard.empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
